hard_mem_1rw_bit_mask_d64_w15_ctrl: RTL and testbench

Initiator-side controller that drives a 64x15 single-port bit-masked SRAM, whether hardened or the RTL model. It presents a valid/ready request port and a valid/yumi read-response port to the client. It generates the SRAM's v/w/addr/data/mask pins and captures the SRAM's 1-cycle read data into a response register. It optionally zero-fills the array after reset before accepting traffic.

---
 rtl/hard_mem_1rw_bit_mask_d64_w15_ctrl.sv | 99 +++++++++
 tb/tb_hard_mem_1rw_bit_mask_d64_w15_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/hard_mem_1rw_bit_mask_d64_w15_ctrl.sv
// Initiator-side controller for a 64x15 single-port bit-masked SRAM: valid/ready requests in, valid/yumi read responses out.
// Define HARD_MEM_CTRL_ZERO_INIT_EN to zero-fill the array after every reset before accepting traffic.
module hard_mem_1rw_bit_mask_d64_w15_ctrl #(
  parameter int width_p = 15,
  parameter int els_p   = 64,
  localparam int addr_width_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [width_p-1:0]       w_mask_i,
  output logic                     ready_o,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i,
  output logic                     init_done_o,
  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  output logic [width_p-1:0]       mem_w_mask_o,
  input  logic [width_p-1:0]       mem_data_i
);

  typedef enum logic {INIT, READY} state_e;

`ifdef HARD_MEM_CTRL_ZERO_INIT_EN
  localparam state_e reset_state_lp = INIT;
`else
  localparam state_e reset_state_lp = READY;
`endif

  state_e                   state_r, state_n;
  logic [addr_width_lp-1:0] count_r;
  logic                     rd_pending_r;
  logic                     v_r;
  logic [width_p-1:0]       data_r;
  logic                     accept;

  always_comb begin
    state_n      = state_r;
    accept       = 1'b0;
    ready_o      = 1'b0;
    init_done_o  = 1'b0;
    mem_v_o      = 1'b0;
    mem_w_o      = w_i;
    mem_addr_o   = addr_i;
    mem_data_o   = data_i;
    mem_w_mask_o = w_mask_i;
    case (state_r)
      INIT: begin
        // Outputs are gated by reset so the sweep pins drop the instant reset rises.
        mem_v_o      = ~reset_i;
        mem_w_o      = 1'b1;
        mem_addr_o   = count_r;
        mem_data_o   = '0;
        mem_w_mask_o = '1;
        if (count_r == addr_width_lp'(els_p - 1)) state_n = READY;
      end
      READY: begin
        init_done_o = ~reset_i;
        ready_o     = ~reset_i & ~rd_pending_r & (~v_r | yumi_i);
        accept      = v_i & ready_o;
        mem_v_o     = accept;
      end
      default: state_n = reset_state_lp;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r      <= reset_state_lp;
      count_r      <= '0;
      rd_pending_r <= 1'b0;
      v_r          <= 1'b0;
      data_r       <= '0;
    end else begin
      state_r      <= state_n;
      if (state_r == INIT) count_r <= count_r + 1'b1;
      rd_pending_r <= accept & ~w_i;
      // A completing read sets v_r even if the client consumes in the same cycle.
      if (rd_pending_r) begin
        v_r    <= 1'b1;
        data_r <= mem_data_i;
      end else if (yumi_i) begin
        v_r    <= 1'b0;
      end
    end
  end

  assign v_o    = v_r;
  assign data_o = data_r;

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_r);

endmodule

// File: tb/tb_hard_mem_1rw_bit_mask_d64_w15_ctrl.sv
// Directed bench for hard_mem_1rw_bit_mask_d64_w15_ctrl with a behavioural 64x15 bit-masked SRAM attached.
// Covers both builds of HARD_MEM_CTRL_ZERO_INIT_EN.
module tb_hard_mem_1rw_bit_mask_d64_w15_ctrl;
  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        v_i, w_i, yumi_i;
  logic [5:0]  addr_i;
  logic [14:0] data_i, w_mask_i;
  logic        ready_o, v_o, init_done_o;
  logic [14:0] data_o;
  logic        mem_v_o, mem_w_o;
  logic [5:0]  mem_addr_o;
  logic [14:0] mem_data_o, mem_w_mask_o;
  logic [14:0] mem_data_i;

  int checks = 0;
  int errors = 0;

  logic [14:0] sram [64];

  always #5 clk_i = ~clk_i;

  hard_mem_1rw_bit_mask_d64_w15_ctrl dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .w_i(w_i), .addr_i(addr_i),
    .data_i(data_i), .w_mask_i(w_mask_i), .ready_o(ready_o), .v_o(v_o),
    .data_o(data_o), .yumi_i(yumi_i), .init_done_o(init_done_o),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_w_mask_o(mem_w_mask_o), .mem_data_i(mem_data_i)
  );

  // SRAM: masked synchronous write, read data valid the cycle after a read.
  initial for (int i = 0; i < 64; i++) sram[i] = 15'h5555;
  always @(posedge clk_i) begin
    if (mem_v_o) begin
      if (mem_w_o) sram[mem_addr_o] <= (sram[mem_addr_o] & ~mem_w_mask_o) | (mem_data_o & mem_w_mask_o);
      else         mem_data_i <= sram[mem_addr_o];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [14:0] d, input logic [14:0] m);
    v_i = 1'b1; w_i = 1'b1; addr_i = a; data_i = d; w_mask_i = m;
    #1 chk("wr_accept", {ready_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_w_mask_o},
           {3'b111, a, d, m});
    tick();
    v_i = 1'b0; w_i = 1'b0;
  endtask

  // Issues a read and checks the response; leaves v_o high for the caller to consume.
  task automatic rd(input string tag, input logic [5:0] a, input logic [14:0] exp, input logic yumi_now);
    v_i = 1'b1; w_i = 1'b0; addr_i = a; yumi_i = yumi_now;
    #1 chk({tag, "_accept"}, {ready_o, mem_v_o, mem_w_o, mem_addr_o}, {3'b110, a});
    tick();
    v_i = 1'b0; yumi_i = 1'b0;
    #1 chk({tag, "_pending"}, {ready_o, v_o}, 2'b00);
    tick();
    chk({tag, "_resp"}, {v_o, data_o}, {1'b1, exp});
  endtask

  task automatic consume();
    yumi_i = 1'b1;
    #1 chk("yumi_ready", ready_o, 1'b1);
    tick();
    yumi_i = 1'b0;
  endtask

  initial begin
    logic saw_mem_v;
    reset_i = 1'b1; v_i = 1'b0; w_i = 1'b0; yumi_i = 1'b0;
    addr_i = '0; data_i = '0; w_mask_i = '0;
    tick(); tick();
    chk("reset_outs", {mem_v_o, ready_o, v_o, data_o, init_done_o}, '0);
    reset_i = 1'b0;

`ifdef HARD_MEM_CTRL_ZERO_INIT_EN
    // Zero-fill sweep: one write per cycle, addresses 0..63.
    for (int i = 0; i < 64; i++) begin
      #1 chk($sformatf("sweep_%0d", i),
             {mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_w_mask_o, ready_o, init_done_o},
             {2'b11, 6'(i), 15'h0000, 15'h7FFF, 2'b00});
      tick();
    end
    #1 chk("init_done", {init_done_o, ready_o, mem_v_o}, 3'b110);
    rd("rd_3f", 6'h3F, 15'h0000, 1'b0);
    consume();
`else
    #1 chk("noinit_first", {ready_o, init_done_o, mem_v_o}, 3'b110);
    saw_mem_v = 1'b0;
    for (int i = 0; i < 70; i++) begin
      tick();
      saw_mem_v |= mem_v_o;
    end
    chk("noinit_no_writes", saw_mem_v, 1'b0);
    wr(6'd5, 15'h0000, 15'h7FFF);
    wr(6'h3F, 15'h0000, 15'h7FFF);
    rd("rd_3f", 6'h3F, 15'h0000, 1'b0);
    consume();
`endif

    // Masked write then read back.
    wr(6'd5, 15'h7FFF, 15'h00FF);
    rd("rd_5", 6'd5, 15'h00FF, 1'b0);
    consume();

    // Stalled response holds data and blocks new requests.
    rd("rd_5_stall", 6'd5, 15'h00FF, 1'b0);
    v_i = 1'b1; w_i = 1'b0; addr_i = 6'd9;
    for (int i = 0; i < 10; i++) begin
      #1 chk($sformatf("stall_%0d", i), {v_o, data_o, ready_o, mem_v_o}, {1'b1, 15'h00FF, 2'b00});
      tick();
    end
    v_i = 1'b0;
    consume();
    #1 chk("after_consume", {v_o, ready_o}, 2'b01);

    // Back-to-back reads with the response consumed as soon as it is valid.
    wr(6'd1, 15'h0111, 15'h7FFF);
    wr(6'd2, 15'h0222, 15'h7FFF);
    wr(6'd3, 15'h0333, 15'h7FFF);
    rd("b2b_1", 6'd1, 15'h0111, 1'b0);
    rd("b2b_2", 6'd2, 15'h0222, 1'b1);
    rd("b2b_3", 6'd3, 15'h0333, 1'b1);
    consume();

    // Read-after-write in consecutive accepted cycles.
    wr(6'd7, 15'h0A0A, 15'h7FFF);
    wr(6'd7, 15'h7FFF, 15'h00F0);
    rd("raw_7", 6'd7, 15'h0AFA, 1'b0);
    consume();

`ifdef HARD_MEM_CTRL_ZERO_INIT_EN
    // Reset in the middle of the sweep restarts it from address 0.
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    #1 chk("mid_sweep_addr", {mem_v_o, mem_addr_o}, {1'b1, 6'd20});
    reset_i = 1'b1;
    #1 chk("mid_sweep_reset", {mem_v_o, ready_o, init_done_o}, 3'b000);
    tick();
    reset_i = 1'b0;
    #1 chk("sweep_restart", {mem_v_o, mem_addr_o}, {1'b1, 6'd0});
    for (int i = 0; i < 63; i++) tick();
    chk("sweep_63", {init_done_o, mem_addr_o}, {1'b0, 6'd63});
    tick();
    chk("sweep_done", {init_done_o, ready_o}, 2'b11);
`else
    // Reset while a read is pending discards the response.
    v_i = 1'b1; w_i = 1'b0; addr_i = 6'd1;
    #1 chk("mid_rd_accept", ready_o, 1'b1);
    tick();
    v_i = 1'b0;
    reset_i = 1'b1;
    #1 chk("mid_rd_reset", {mem_v_o, ready_o, v_o, data_o, init_done_o}, '0);
    tick();
    reset_i = 1'b0;
    #1 chk("mid_rd_release", {ready_o, init_done_o, v_o}, 3'b110);
    tick();
    chk("mid_rd_no_resp", v_o, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
